bcd_seg_scan_driver: RTL and testbench
======================================

Name: bcd_seg_scan_driver

Overview:
- Display-side consumer of the BCD key-count values. Takes four BCD digits (DK3..DK0) and drives a time-multiplexed common-digit 7-segment display.
- Registers input on frame boundaries so the display never tears.
- Handles leading-zero blanking, per-digit decimal points, anti-ghost dead time, and a frame-done strobe.
- Sits between the counter blocks and the board's segment/digit pins.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- SCAN_HZ, 1000, per-digit slot rate; DIV = CLK_HZ/SCAN_HZ clocks per slot (DIV >= 4 required).
- BLANK_CYC, 500, clocks at start of each slot with all digits off (anti-ghost); must be < DIV.
- SEG_ACTIVE_LOW, 1, 1 = segment/dp outputs active-low.
- DIG_ACTIVE_LOW, 1, 1 = digit-select outputs active-low.
- LZ_BLANK, 1, 1 = suppress leading zeros on DK3..DK1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- bcd_in  in  16  [15:12]=DK3, [11:8]=DK2, [7:4]=DK1, [3:0]=DK0.
- dp_in  in  4  decimal point per digit, bit i = DKi, 1 = lit.
- en  in  1  display enable.
- seg_out  out  7  segments, bit0=a .. bit6=g.
- dp_out  out  1  decimal point segment.
- dig_sel  out  4  digit enables, bit i = DKi.
- frame_done  out  1  one-cycle pulse per completed 4-digit frame.

Behaviour:
- **Reset (sync, rst=1 at clk edge):**
  - slot counter=0, digit index=0, shadow regs (bcd, dp)=0, frame_done=0.
  - All outputs at inactive level: seg_out=7'h7F, dp_out=1, dig_sel=4'hF for active-low defaults; all zero for active-high.
  - rst asserted mid-scan aborts the slot immediately; scanning restarts from DK0, slot cycle 0.
- **Slot counter:** counts 0..DIV-1, wraps to 0. The "tick" is the cycle with count==DIV-1.
- **Digit index:** 0..3, advances on tick, wraps 3->0.
- **Frame boundary:** on the tick where index==3:
  - bcd_in and dp_in are captured into the shadow registers.
  - frame_done=1 for that one cycle.
  - Inputs never affect display mid-frame.
- **Outputs are registered** from the current index, slot count and shadow, so they lag index/count by one clk.
- **Dead time:** while count < BLANK_CYC, dig_sel is all inactive and seg/dp are inactive. Otherwise dig_sel activates only digit[index].
- **Decode (active-high form, then inverted if SEG_ACTIVE_LOW):**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles A..F show dash = 40.
- **Leading-zero blanking (LZ_BLANK=1):**
  - DK3 blank if its value is 0.
  - DK2 blank if DK3 blanked and DK2 is 0; DK1 likewise from DK2.
  - DK0 is never blanked.
  - A blank digit drives seg inactive, but its dp still follows the dp shadow.
  - Non-BCD nibbles count as nonzero.
- **en=0:** dig_sel, seg_out and dp_out are all inactive. Slot counter, index, snapshot and frame_done keep running, so re-enable resumes mid-frame without a glitch.
- **Simultaneous events:**
  - rst has priority over everything.
  - bcd_in changing in the same cycle as the snapshot: the value present at that edge is the one captured.

Test Plan (CLK_HZ=40, SCAN_HZ=10 so DIV=4, BLANK_CYC=1, active-low defaults):
1. **Reset:** rst=1 for 3 clks -> seg_out=7F, dp_out=1, dig_sel=F, frame_done=0. First frame_done occurs 16 clks after rst release.
2. **Leading-zero blanking:** bcd_in=16'h0042 held 2 frames -> in frame 2:
   - DK0 slot: dig_sel=E, seg_out=24.
   - DK1 slot: dig_sel=D, seg_out=19.
   - DK2/DK3 slots: seg_out=7F.
   - Each slot has 1 blank cycle with dig_sel=F.
3. **Frame snapshot:** frame showing 0042; change bcd_in to 0099 during the DK1 slot -> DK2/DK3 slots still reflect 0042. The next frame shows 99 (seg 10 in DK0/DK1 slots), changing only after the frame_done pulse.
4. **Dash and inner zero:** bcd_in=16'h1A05, dp_in=4'b0100 -> DK3=79 (the "1"), DK2 seg=3F (dash) with dp_out=0, DK1 seg=40 (zero shown, not blanked), DK0 seg=12.
5. **Enable:** en=0 for 1 full frame -> dig_sel=F, seg_out=7F throughout while frame_done still pulses every 16 clks. en=1 -> display resumes at the current index.
6. **Reset mid-scan:** rst=1 for one clk during the DK2 slot -> next slot is DK0, shadow=0000, and DK0 shows "0" (seg 40) until the next snapshot.

Source files
------------

// File: rtl/bcd_seg_scan_driver.sv
// bcd_seg_scan_driver
// Time-multiplexes four BCD digits onto a common-digit 7-segment display.
// A new value is latched only at frame boundaries, so a digit never changes
// in the middle of a frame. Each digit slot starts with a short dead time
// that stops ghosting between digits. Leading zeros can be suppressed, and
// a one-cycle frame_done strobe is raised after every completed frame.
module bcd_seg_scan_driver #(
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYC      = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int LZ_BLANK       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        en,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  dig_sel,
  output logic        frame_done
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] LAST_COUNT = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYC);

  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [3:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  logic [CW-1:0] count;
  logic [1:0]    idx;
  logic [15:0]   shadow_bcd;
  logic [3:0]    shadow_dp;
  logic          tick;

  logic [3:0]    digit;
  logic          blank3, blank2, blank1, blank_cur;
  logic          show;
  logic [6:0]    seg_hi, seg_next;
  logic          dp_hi, dp_next;
  logic [3:0]    dig_hi, dig_next;

  // Active-high segment pattern (bit0=a .. bit6=g); non-BCD nibbles show a dash
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  assign tick = (count == LAST_COUNT);

  // Slot counter, digit index, frame snapshot and frame-done strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      idx        <= 2'd0;
      shadow_bcd <= 16'h0000;
      shadow_dp  <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && (idx == 2'd3);
      if (tick) begin
        count <= '0;
        idx   <= idx + 2'd1;
        if (idx == 2'd3) begin
          shadow_bcd <= bcd_in;
          shadow_dp  <= dp_in;
        end
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  // Work out what the current slot should show, including blanking and polarity
  always_comb begin
    digit     = shadow_bcd[{idx, 2'b00} +: 4];
    blank3    = (LZ_BLANK != 0) && (shadow_bcd[15:12] == 4'h0);
    blank2    = blank3 && (shadow_bcd[11:8] == 4'h0);
    blank1    = blank2 && (shadow_bcd[7:4] == 4'h0);
    blank_cur = 1'b0;
    case (idx)
      2'd3:    blank_cur = blank3;
      2'd2:    blank_cur = blank2;
      2'd1:    blank_cur = blank1;
      default: blank_cur = 1'b0;
    endcase
    show   = en && (count >= BLANK_END);
    seg_hi = 7'h00;
    if (show && !blank_cur) begin
      seg_hi = decode(digit);
    end
    dp_hi    = show && shadow_dp[idx];
    dig_hi   = show ? (4'b0001 << idx) : 4'b0000;
    seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    dp_next  = (SEG_ACTIVE_LOW != 0) ? ~dp_hi : dp_hi;
    dig_next = (DIG_ACTIVE_LOW != 0) ? ~dig_hi : dig_hi;
  end

  // Register the pin drivers so the board sees glitch-free outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out <= SEG_OFF;
      dp_out  <= DP_OFF;
      dig_sel <= DIG_OFF;
    end else begin
      seg_out <= seg_next;
      dp_out  <= dp_next;
      dig_sel <= dig_next;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan_driver.sv
// tb_bcd_seg_scan_driver
// Self-checking bench: a cycle model pushes expected outputs into a queue at
// each rising edge and they are compared on the following falling edge.
// Directed frame captures check the hand-derived display patterns.
module tb_bcd_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        en;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  bcd_seg_scan_driver #(
    .CLK_HZ(40),
    .SCAN_HZ(10),
    .BLANK_CYC(1),
    .SEG_ACTIVE_LOW(1),
    .DIG_ACTIVE_LOW(1),
    .LZ_BLANK(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bcd_in(bcd_in),
    .dp_in(dp_in),
    .en(en),
    .seg_out(seg_out),
    .dp_out(dp_out),
    .dig_sel(dig_sel),
    .frame_done(frame_done)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  localparam logic [6:0] DEC [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                                        7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h40, 7'h40,
                                        7'h40, 7'h40, 7'h40, 7'h40};

  // Count one comparison and report it when it disagrees
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Digit k is blank when it and every more significant digit are zero
  function automatic logic isBlank(input logic [15:0] v, input int k);
    logic [3:0] nib;
    if (k == 0) return 1'b0;
    for (int j = k; j < 4; j++) begin
      nib = 4'(v >> (4 * j));
      if (nib != 4'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_bcd = 16'h0;
  logic [3:0]  m_dp  = 4'h0;

  // Reference model: expected outputs after this edge go to the scoreboard
  always @(posedge clk) begin
    exp_t e;
    logic [3:0] nib;
    if (rst) begin
      e.seg = 7'h7F; e.dp = 1'b1; e.dig = 4'hF; e.fd = 1'b0;
      m_cnt = 0; m_idx = 0; m_bcd = 16'h0; m_dp = 4'h0;
    end else begin
      nib = 4'(m_bcd >> (4 * m_idx));
      if (en && m_cnt >= 1) begin
        e.dig = ~(4'b0001 << m_idx);
        e.seg = isBlank(m_bcd, m_idx) ? 7'h7F : ~DEC[nib];
        e.dp  = ~m_dp[m_idx];
      end else begin
        e.dig = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      end
      e.fd = (m_cnt == 3) && (m_idx == 3);
      if (m_cnt == 3) begin
        m_cnt = 0;
        if (m_idx == 3) begin
          m_bcd = bcd_in;
          m_dp  = dp_in;
        end
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    sb.push_back(e);
  end

  // Scoreboard comparison on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("sb_seg", 16'(seg_out), 16'(e.seg));
      checkOutput("sb_dp", 16'(dp_out), 16'(e.dp));
      checkOutput("sb_dig", 16'(dig_sel), 16'(e.dig));
      checkOutput("sb_fd", 16'(frame_done), 16'(e.fd));
    end
  end

  logic [6:0] cs [1:16];
  logic       cd [1:16];
  logic [3:0] cg [1:16];
  logic       cf [1:16];

  // Wait (bounded) until frame_done is seen on a falling edge
  task automatic waitFrameDone();
    int n = 0;
    while (frame_done !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (frame_done !== 1'b1) checkOutput("fd_timeout", 16'(frame_done), 16'h1);
  endtask

  // Capture the 16 samples of the frame following a frame_done pulse
  task automatic applyStimulus(input int chg_k, input logic [15:0] chg_val);
    waitFrameDone();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      cs[k] = seg_out; cd[k] = dp_out; cg[k] = dig_sel; cf[k] = frame_done;
      if (k == chg_k) bcd_in = chg_val;
    end
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; bcd_in = 16'h0000; dp_in = 4'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_seg", 16'(seg_out), 16'h7F);
    checkOutput("rst_dp", 16'(dp_out), 16'h1);
    checkOutput("rst_dig", 16'(dig_sel), 16'hF);
    checkOutput("rst_fd", 16'(frame_done), 16'h0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checkOutput("fd_first", 16'(frame_done), (k == 16) ? 16'h1 : 16'h0);
    end

    // Leading-zero blanking, held for two frames
    bcd_in = 16'h0042;
    applyStimulus(0, 16'h0);
    applyStimulus(0, 16'h0);
    checkOutput("lz_dead0", 16'(cg[1]), 16'hF);
    checkOutput("lz_dig0", 16'(cg[2]), 16'hE);
    checkOutput("lz_seg0", 16'(cs[2]), 16'h24);
    checkOutput("lz_dead1", 16'(cg[5]), 16'hF);
    checkOutput("lz_dig1", 16'(cg[6]), 16'hD);
    checkOutput("lz_seg1", 16'(cs[6]), 16'h19);
    checkOutput("lz_seg2", 16'(cs[10]), 16'h7F);
    checkOutput("lz_seg3", 16'(cs[14]), 16'h7F);

    // Snapshot: change during the DK1 slot must not reach DK2/DK3
    applyStimulus(6, 16'h0099);
    checkOutput("snap_seg0", 16'(cs[2]), 16'h24);
    checkOutput("snap_seg2", 16'(cs[10]), 16'h7F);
    checkOutput("snap_seg3", 16'(cs[14]), 16'h7F);
    checkOutput("snap_fd", 16'(cf[16]), 16'h1);
    applyStimulus(0, 16'h0);
    checkOutput("new_seg0", 16'(cs[2]), 16'h10);
    checkOutput("new_seg1", 16'(cs[6]), 16'h10);
    checkOutput("new_seg2", 16'(cs[10]), 16'h7F);

    // Dash, inner zero and decimal point
    bcd_in = 16'h1A05; dp_in = 4'b0100;
    applyStimulus(0, 16'h1A05);
    applyStimulus(0, 16'h1A05);
    checkOutput("dash_seg3", 16'(cs[14]), 16'h79);
    checkOutput("dash_dig3", 16'(cg[14]), 16'h7);
    checkOutput("dash_seg2", 16'(cs[10]), 16'h3F);
    checkOutput("dash_dp2", 16'(cd[10]), 16'h0);
    checkOutput("dash_dig2", 16'(cg[10]), 16'hB);
    checkOutput("dash_seg1", 16'(cs[6]), 16'h40);
    checkOutput("dash_dp1", 16'(cd[6]), 16'h1);
    checkOutput("dash_seg0", 16'(cs[2]), 16'h12);

    // Disabled for a full frame: dark display, strobe keeps running
    en = 1'b0;
    applyStimulus(0, 16'h1A05);
    for (int k = 1; k <= 16; k++) begin
      checkOutput("en_dig", 16'(cg[k]), 16'hF);
      checkOutput("en_seg", 16'(cs[k]), 16'h7F);
    end
    checkOutput("en_fd", 16'(cf[16]), 16'h1);
    en = 1'b1;
    applyStimulus(0, 16'h1A05);
    checkOutput("reen_dig0", 16'(cg[2]), 16'hE);
    checkOutput("reen_seg0", 16'(cs[2]), 16'h12);

    // Reset during the DK2 slot restarts at DK0 with a cleared snapshot
    waitFrameDone();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_seg", 16'(seg_out), 16'h7F);
    checkOutput("mid_rst_dig", 16'(dig_sel), 16'hF);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_dead", 16'(dig_sel), 16'hF);
    @(negedge clk);
    checkOutput("mid_dig0", 16'(dig_sel), 16'hE);
    checkOutput("mid_seg0", 16'(seg_out), 16'h40);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
